// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU/mux codes, FSM states.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluSlt = 3'd4;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  localparam logic [1:0] AluBReg   = 2'd0;
  localparam logic [1:0] AluBFour  = 2'd1;
  localparam logic [1:0] AluBImm   = 2'd2;
  localparam logic [1:0] AluBBrOff = 2'd3;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StAddr   = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StWbR    = 4'd7,
    StWbMem  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StHalt   = 4'd11
  } state_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct decode: post-DECODE state, R-type ALU op and legality flags.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output state_e     dec_next_o,
  output logic       opcode_ok_o,
  output logic [2:0] r_alu_op_o,
  output logic       funct_ok_o
);

  always_comb begin
    dec_next_o  = StFetch;
    opcode_ok_o = 1'b1;
    case (opcode_i)
      OpRtype:    dec_next_o = StExecR;
      OpLw, OpSw: dec_next_o = StAddr;
      OpBeq:      dec_next_o = StBranch;
      OpJ:        dec_next_o = StJump;
      OpAddi:     dec_next_o = StExecI;
      default:    opcode_ok_o = 1'b0;
    endcase
  end

  always_comb begin
    r_alu_op_o = AluAdd;
    funct_ok_o = 1'b1;
    case (funct_i)
      FnAdd:   r_alu_op_o = AluAdd;
      FnSub:   r_alu_op_o = AluSub;
      FnAnd:   r_alu_op_o = AluAnd;
      FnOr:    r_alu_op_o = AluOr;
      FnSlt:   r_alu_op_o = AluSlt;
      default: funct_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS controller FSM with memory-wait timeout and retired-instruction counter.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to halt on illegal opcode/funct instead of skipping it.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned WaitW = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_err_q, bus_err_d;
  logic               illegal_q, illegal_d;
  logic               rdst_q, rdst_d;
  logic               retire;
  logic               illegal_hit;

  state_e             dec_next;
  logic               opcode_ok;
  logic               funct_ok;
  logic [2:0]         r_alu_op;

  // The branch condition is resolved in the datapath, not here.
  logic               unused_zero;
  assign unused_zero = zero;

  mips_ctrl_decode u_decode (
    .opcode_i    (opcode),
    .funct_i     (funct),
    .dec_next_o  (dec_next),
    .opcode_ok_o (opcode_ok),
    .r_alu_op_o  (r_alu_op),
    .funct_ok_o  (funct_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
      rdst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
      rdst_q    <= rdst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_err_d   = bus_err_q;
    illegal_d   = illegal_q;
    rdst_d      = rdst_q;
    retire      = 1'b0;
    illegal_hit = 1'b0;

    unique case (state_q)
      StFetch: begin
        wait_d = '0;
        if (instr_valid) state_d = StDecode;
      end
      StDecode: begin
        if (opcode_ok) begin
          state_d = dec_next;
          rdst_d  = (opcode == OpRtype);
        end else begin
          illegal_hit = 1'b1;
        end
      end
      StExecR: begin
        if (funct_ok) state_d = StWbR;
        else          illegal_hit = 1'b1;
      end
      StExecI: state_d = StWbR;
      StAddr: begin
        wait_d  = '0;
        state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd, StMemWr: begin
        if (mem_ack) begin
          state_d = (state_q == StMemRd) ? StWbMem : StFetch;
          retire  = (state_q == StMemWr);
        end else if (wait_q == WaitW'(MEM_TMO - 1)) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWbR, StWbMem, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    if (illegal_hit) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      state_d   = StHalt;
      illegal_d = 1'b1;
`else
      state_d   = StFetch;
`endif
    end

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Outputs are gated by reset so an in-flight strobe drops the instant reset asserts.
  always_comb begin
    instr_ready   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    alu_src_b     = AluBReg;
    pc_src        = PcPlus4;
    alu_op        = AluAdd;

    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          instr_ready = 1'b1;
          alu_src_b   = AluBFour;
          if (instr_valid) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PcPlus4;
          end
        end
        StDecode: alu_src_b = AluBBrOff;
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = r_alu_op;
        end
        StExecI, StAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = AluBImm;
        end
        StMemRd: mem_req = 1'b1;
        StMemWr: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        StWbR: begin
          reg_write = 1'b1;
          reg_dst   = rdst_q;
        end
        StWbMem: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = AluSub;
          pc_write_cond = 1'b1;
          pc_src        = PcBranch;
        end
        StJump: begin
          pc_write = 1'b1;
          pc_src   = PcJump;
        end
        default: ;
      endcase
    end
  end

  assign state_o     = state_q;
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl (CNT_W=4 so the retired counter wraps quickly).
module tb_mips_mc_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ack;
  logic       ir_write, pc_write, pc_write_cond, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, mem_req, mem_we;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic       illegal, bus_err;
  logic [3:0] retired_cnt;

  int errors = 0;
  int checks = 0;
  int reqs;

  mips_mc_ctrl #(
    .CNT_W   (4),
    .MEM_TMO (15)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ack       (mem_ack),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op),
    .state_o       (state_o),
    .illegal       (illegal),
    .bus_err       (bus_err),
    .retired_cnt   (retired_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  // Presents an instruction in FETCH and leaves the bench in cycle 1 (DECODE).
  task automatic accept(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct = fn;
    instr_valid = 1'b1;
    #1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b1;
    opcode = 6'b000000;
    funct = 6'b100000;
    zero = 1'b0;
    mem_ack = 1'b0;
    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'd0);
    chk("rst_retired", 32'(retired_cnt), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    instr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    // add
    opcode = 6'b000000;
    funct = 6'b100000;
    instr_valid = 1'b1;
    #1;
    chk("add_c0_ir_write", 32'(ir_write), 32'd1);
    chk("add_c0_pc_write", 32'(pc_write), 32'd1);
    chk("add_c0_pc_src", 32'(pc_src), 32'd0);
    step();
    instr_valid = 1'b0;
    chk("add_c1_state", 32'(state_o), 32'd1);
    chk("add_c1_alu_src_b", 32'(alu_src_b), 32'd3);
    chk("add_c1_ir_write", 32'(ir_write), 32'd0);
    step();
    chk("add_c2_state", 32'(state_o), 32'd2);
    chk("add_c2_alu_op", 32'(alu_op), 32'd0);
    step();
    chk("add_c3_state", 32'(state_o), 32'd7);
    chk("add_c3_reg_write", 32'(reg_write), 32'd1);
    chk("add_c3_reg_dst", 32'(reg_dst), 32'd1);
    step();
    chk("add_c4_retired", 32'(retired_cnt), 32'd1);
    chk("add_c4_ready", 32'(instr_ready), 32'd1);

    // slt, then sub
    accept(6'b000000, 6'b101010);
    step();
    chk("slt_alu_op", 32'(alu_op), 32'd4);
    step();
    step();
    chk("slt_retired", 32'(retired_cnt), 32'd2);
    accept(6'b000000, 6'b100010);
    step();
    chk("sub_alu_op", 32'(alu_op), 32'd1);
    step();
    step();
    chk("sub_retired", 32'(retired_cnt), 32'd3);

    // addi
    accept(6'b001000, 6'b000000);
    step();
    chk("addi_c2_state", 32'(state_o), 32'd3);
    chk("addi_c2_alu_src_b", 32'(alu_src_b), 32'd2);
    step();
    chk("addi_c3_state", 32'(state_o), 32'd7);
    chk("addi_c3_reg_write", 32'(reg_write), 32'd1);
    chk("addi_c3_reg_dst", 32'(reg_dst), 32'd0);
    step();
    chk("addi_retired", 32'(retired_cnt), 32'd4);

    // lw with mem_ack in the third MEM_RD cycle
    accept(6'b100011, 6'b000000);
    step();
    chk("lw_c2_state", 32'(state_o), 32'd4);
    chk("lw_c2_mem_req", 32'(mem_req), 32'd0);
    step();
    chk("lw_c3_state", 32'(state_o), 32'd5);
    chk("lw_c3_mem_we", 32'(mem_we), 32'd0);
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req) reqs++;
      if (i == 2) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    chk("lw_mem_req_cycles", 32'(reqs), 32'd3);
    chk("lw_c6_state", 32'(state_o), 32'd8);
    chk("lw_c6_mem_req", 32'(mem_req), 32'd0);
    chk("lw_c6_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("lw_c6_reg_write", 32'(reg_write), 32'd1);
    chk("lw_c6_reg_dst", 32'(reg_dst), 32'd0);
    step();
    chk("lw_c7_state", 32'(state_o), 32'd0);
    chk("lw_c7_retired", 32'(retired_cnt), 32'd5);

    // mem_ack in FETCH is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("fetch_ack_ignored", 32'(state_o), 32'd0);

    // sw with immediate ack
    accept(6'b101011, 6'b000000);
    step();
    step();
    chk("sw_c3_state", 32'(state_o), 32'd6);
    chk("sw_c3_mem_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sw_c4_state", 32'(state_o), 32'd0);
    chk("sw_c4_retired", 32'(retired_cnt), 32'd6);

    // beq
    accept(6'b000100, 6'b000000);
    step();
    chk("beq_state", 32'(state_o), 32'd9);
    chk("beq_pc_write_cond", 32'(pc_write_cond), 32'd1);
    chk("beq_pc_src", 32'(pc_src), 32'd1);
    chk("beq_alu_op", 32'(alu_op), 32'd1);
    chk("beq_pc_write", 32'(pc_write), 32'd0);
    step();
    chk("beq_retired", 32'(retired_cnt), 32'd7);

    // j
    accept(6'b000010, 6'b000000);
    step();
    chk("j_state", 32'(state_o), 32'd10);
    chk("j_pc_write", 32'(pc_write), 32'd1);
    chk("j_pc_src", 32'(pc_src), 32'd2);
    step();
    chk("j_retired", 32'(retired_cnt), 32'd8);

    // illegal funct
    accept(6'b000000, 6'b111111);
    step();
    step();
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    chk("ill_fn_state", 32'(state_o), 32'd11);
    chk("ill_fn_flag", 32'(illegal), 32'd1);
`else
    chk("ill_fn_state", 32'(state_o), 32'd0);
    chk("ill_fn_flag", 32'(illegal), 32'd0);
`endif
    chk("ill_fn_retired", 32'(retired_cnt), 32'd8);

    // illegal opcode
    do_reset();
    accept(6'b111111, 6'b000000);
    chk("ill_op_c1_state", 32'(state_o), 32'd1);
    step();
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    chk("ill_op_state", 32'(state_o), 32'd11);
    chk("ill_op_flag", 32'(illegal), 32'd1);
`else
    chk("ill_op_state", 32'(state_o), 32'd0);
    chk("ill_op_flag", 32'(illegal), 32'd0);
`endif
    chk("ill_op_retired", 32'(retired_cnt), 32'd0);

    // reset during MEM_RD
    do_reset();
    accept(6'b100011, 6'b000000);
    step();
    step();
    chk("rst_mem_pre_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rst_mem_state", 32'(state_o), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("rst_mem_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("rst_mem_no_reg_write", 32'(reg_write), 32'd0);
      step();
    end

    // sw bus timeout
    do_reset();
    accept(6'b101011, 6'b000000);
    step();
    step();
    reqs = 0;
    for (int i = 0; i < 15; i++) begin
      if (state_o == 4'd6 && mem_req && mem_we) reqs++;
      step();
    end
    chk("tmo_req_cycles", 32'(reqs), 32'd15);
    chk("tmo_state", 32'(state_o), 32'd11);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_retired", 32'(retired_cnt), 32'd0);
    chk("tmo_mem_req", 32'(mem_req), 32'd0);
    chk("tmo_ready", 32'(instr_ready), 32'd0);
    instr_valid = 1'b1;
    #1;
    chk("halt_ir_write", 32'(ir_write), 32'd0);
    step();
    step();
    chk("halt_persist", 32'(state_o), 32'd11);
    chk("halt_bus_err_sticky", 32'(bus_err), 32'd1);
    instr_valid = 1'b0;

    // 16 back-to-back jumps wrap the 4-bit counter
    do_reset();
    opcode = 6'b000010;
    instr_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (i == 44) chk("wrap_15", 32'(retired_cnt), 32'd15);
    end
    instr_valid = 1'b0;
    chk("wrap_0", 32'(retired_cnt), 32'd0);
    chk("wrap_state", 32'(state_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
